tl_a_channel_arbiter: RTL and testbench

- Two-requester arbiter sharing one slave port of the 53-bit A / 43-bit D valid/ready bus between requester 0 (data-memory stage) and requester 1 (instruction fetch).
- Arbitrates A-channel requests round-robin and stamps a source bit so responses can be routed back.
- Routes each D-channel response to its owner and tracks outstanding transactions per requester.
- Sits between the pipeline master ports and the single slave.

---
 rtl/tl_a_channel_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tl_a_channel_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_channel_arbiter.sv
// Two-requester arbiter for one slave port of the A/D valid/ready bus: round-robin A grants
// with a stamped source bit, D routing by source bit. Define ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 first).
module tl_a_channel_arbiter #(
  parameter int A_W       = 53,
  parameter int D_W       = 43,
  parameter int A_SRC_BIT = 32,
  parameter int D_SRC_BIT = 32,
  parameter int MAX_OUT   = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           m0_a_valid,
  output logic           m0_a_ready,
  input  logic [A_W-1:0] m0_a_channel,
  input  logic           m1_a_valid,
  output logic           m1_a_ready,
  input  logic [A_W-1:0] m1_a_channel,
  output logic           m0_d_valid,
  input  logic           m0_d_ready,
  output logic [D_W-1:0] m0_d_channel,
  output logic           m0_d_error,
  output logic           m1_d_valid,
  input  logic           m1_d_ready,
  output logic [D_W-1:0] m1_d_channel,
  output logic           m1_d_error,
  output logic           s_a_valid,
  input  logic           s_a_ready,
  output logic [A_W-1:0] s_a_channel,
  input  logic           s_d_valid,
  output logic           s_d_ready,
  input  logic [D_W-1:0] s_d_channel,
  input  logic           s_d_error,
  input  logic           backpressureslave,
  output logic           unexpected_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [2:0] MaxCnt = 3'(MAX_OUT);

  state_e         state_q, state_d;
  logic [2:0]     cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           unexp_q, unexp_d;
  logic           tie_sel;
  logic           elig0, elig1;
  logic           grant_vld, grant_idx;
  logic [A_W-1:0] grant_pl;
  logic           a_fire, d_fire, d_dst;
  logic           inc0, inc1, dec0, dec1;

  // A requester at its outstanding limit is held off; the limit uses registered counts only,
  // so a response retiring in the same cycle does not admit a new request until the next one.
  assign elig0 = m0_a_valid && (cnt0_q < MaxCnt) && !backpressureslave;
  assign elig1 = m1_a_valid && (cnt1_q < MaxCnt) && !backpressureslave;

`ifdef ARB_FIXED_PRIORITY_EN
  assign tie_sel = 1'b0;
`else
  logic rr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (a_fire) begin
      rr_q <= ~grant_idx;
    end
  end

  assign tie_sel = rr_q;
`endif

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    case (state_q)
      IDLE: begin
        grant_vld = elig0 | elig1;
        grant_idx = (elig0 && elig1) ? tie_sel : elig1;
      end
      // Once offered, the grant is held until the handshake completes, ignoring the other
      // requester and slave backpressure.
      LOCK0: begin
        grant_vld = m0_a_valid;
        grant_idx = 1'b0;
      end
      LOCK1: begin
        grant_vld = m1_a_valid;
        grant_idx = 1'b1;
      end
      default: begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
      end
    endcase
  end

  always_comb begin
    grant_pl            = grant_idx ? m1_a_channel : m0_a_channel;
    grant_pl[A_SRC_BIT] = grant_idx;
  end

  // Every combinational output is forced low while reset is asserted.
  assign s_a_valid   = reset & grant_vld;
  assign s_a_channel = reset ? grant_pl : '0;
  assign m0_a_ready  = reset & grant_vld & ~grant_idx & s_a_ready;
  assign m1_a_ready  = reset & grant_vld &  grant_idx & s_a_ready;
  assign a_fire      = s_a_valid & s_a_ready;

  assign d_dst        = s_d_channel[D_SRC_BIT];
  assign m0_d_valid   = reset & s_d_valid & ~d_dst;
  assign m1_d_valid   = reset & s_d_valid &  d_dst;
  assign s_d_ready    = reset & (d_dst ? m1_d_ready : m0_d_ready);
  assign m0_d_channel = reset ? s_d_channel : '0;
  assign m1_d_channel = reset ? s_d_channel : '0;
  assign m0_d_error   = reset & s_d_error;
  assign m1_d_error   = reset & s_d_error;
  assign d_fire       = s_d_valid & s_d_ready;

  assign inc0 = a_fire & ~grant_idx;
  assign inc1 = a_fire &  grant_idx;
  assign dec0 = d_fire & ~d_dst;
  assign dec1 = d_fire &  d_dst;

  function automatic logic [2:0] next_cnt(input logic [2:0] cnt, input logic inc,
                                          input logic dec);
    logic [2:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + 3'd1;
    end else if (dec && !inc && (cnt != 3'd0)) begin
      nxt = cnt - 3'd1;
    end
    return nxt;
  endfunction

  always_comb begin
    cnt0_d  = next_cnt(cnt0_q, inc0, dec0);
    cnt1_d  = next_cnt(cnt1_q, inc1, dec1);
    unexp_d = unexp_q | (dec0 && (cnt0_q == 3'd0)) | (dec1 && (cnt1_q == 3'd0));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (grant_vld && !s_a_ready) state_d = grant_idx ? LOCK1 : LOCK0;
      // Leaving on a dropped valid covers a requester that withdraws mid-handshake.
      LOCK0, LOCK1: if (a_fire || !grant_vld) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt0_q  <= 3'd0;
      cnt1_q  <= 3'd0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      unexp_q <= unexp_d;
    end
  end

  assign unexpected_resp = unexp_q;

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Directed bench for tl_a_channel_arbiter: A payloads go through a scoreboard queue,
// everything else is compared against constants derived from the arbiter's behaviour.
module tb_tl_a_channel_arbiter;
  localparam int A_W = 53;
  localparam int D_W = 43;
  localparam int SRC = 32;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
  logic [A_W-1:0] m0_a_channel, m1_a_channel, s_a_channel;
  logic           m0_d_valid, m0_d_ready, m0_d_error, m1_d_valid, m1_d_ready, m1_d_error;
  logic [D_W-1:0] m0_d_channel, m1_d_channel, s_d_channel;
  logic           s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error;
  logic           backpressureslave, unexpected_resp;

  int             checks = 0;
  int             errors = 0;
  logic [A_W-1:0] sb_a[$];
  logic [3:0]     alt;
  logic           w;
  logic [A_W-1:0] p0;

  tl_a_channel_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_channel(m0_a_channel),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_channel(m1_a_channel),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_channel(m0_d_channel),
    .m0_d_error(m0_d_error),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_channel(m1_d_channel),
    .m1_d_error(m1_d_error),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_channel(s_a_channel),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_channel(s_d_channel),
    .s_d_error(s_d_error),
    .backpressureslave(backpressureslave), .unexpected_resp(unexpected_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A_W-1:0] mk_a(input logic [6:0] op, input logic [13:0] addr,
                                          input logic [31:0] data);
    return {addr, op, data};
  endfunction

  function automatic logic [A_W-1:0] stamp(input logic [A_W-1:0] a, input logic idx);
    logic [A_W-1:0] r;
    r = a;
    r[SRC] = idx;
    return r;
  endfunction

  function automatic logic [D_W-1:0] mk_d(input logic dst, input logic [31:0] data);
    logic [D_W-1:0] d;
    d = '0;
    d[31:0] = data;
    d[SRC] = dst;
    d[D_W-1:33] = 10'h2A5;
    return d;
  endfunction

  // Slave side of the scoreboard: every accepted A beat must match the oldest expectation.
  task automatic observe_a(input string tag);
    logic [A_W-1:0] exp;
    if (s_a_valid && s_a_ready) begin
      check({tag, "_sb_nonempty"}, 64'(sb_a.size() > 0), 64'd1);
      if (sb_a.size() > 0) begin
        exp = sb_a.pop_front();
        check(tag, 64'(s_a_channel), 64'(exp));
      end
    end
  endtask

  task automatic clear_inputs();
    m0_a_valid = 1'b0; m1_a_valid = 1'b0;
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_error = 1'b0;
    m0_d_ready = 1'b0; m1_d_ready = 1'b0; backpressureslave = 1'b0;
    s_d_channel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_unexp_clr"}, 64'(unexpected_resp), 64'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic d_resp(input string tag, input logic dst);
    s_d_valid = 1'b1; s_d_channel = mk_d(dst, 32'h1234); m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    #1;
    check({tag, "_sd_ready"}, 64'(s_d_ready), 64'd1);
    tick();
    s_d_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    m0_a_channel = '0; m1_a_channel = '0;

    // Outputs while in reset
    #2;
    m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
    m0_a_channel = mk_a(OP_STORE, 14'd1, 32'd1);
    s_d_valid = 1'b1; s_d_channel = mk_d(1'b0, 32'hBEEF); s_d_error = 1'b1;
    m0_d_ready = 1'b1; m1_d_ready = 1'b1;
    #1;
    check("rst_s_a_valid", 64'(s_a_valid), 64'd0);
    check("rst_m0_a_ready", 64'(m0_a_ready), 64'd0);
    check("rst_m1_a_ready", 64'(m1_a_ready), 64'd0);
    check("rst_s_a_channel", 64'(s_a_channel), 64'd0);
    check("rst_m0_d_valid", 64'(m0_d_valid), 64'd0);
    check("rst_s_d_ready", 64'(s_d_ready), 64'd0);
    check("rst_m0_d_error", 64'(m0_d_error), 64'd0);
    check("rst_unexp", 64'(unexpected_resp), 64'd0);
    clear_inputs();
    #17;
    reset = 1'b1;
    tick();

    // Store from requester 0 passes through in the same cycle; its response routes back
    m0_a_channel = mk_a(OP_STORE, 14'd10, 32'd20);
    m0_a_valid = 1'b1; s_a_ready = 1'b1;
    sb_a.push_back(stamp(m0_a_channel, 1'b0));
    #1;
    check("t1_s_a_valid", 64'(s_a_valid), 64'd1);
    check("t1_m0_a_ready", 64'(m0_a_ready), 64'd1);
    check("t1_m1_a_ready", 64'(m1_a_ready), 64'd0);
    check("t1_src_bit", 64'(s_a_channel[SRC]), 64'd0);
    observe_a("t1_a_payload");
    tick();
    m0_a_valid = 1'b0;
    s_d_valid = 1'b1; s_d_channel = mk_d(1'b0, 32'hCAFE); m0_d_ready = 1'b1;
    #1;
    check("t1_m0_d_valid", 64'(m0_d_valid), 64'd1);
    check("t1_m1_d_valid", 64'(m1_d_valid), 64'd0);
    check("t1_s_d_ready", 64'(s_d_ready), 64'd1);
    check("t1_m0_d_channel", 64'(m0_d_channel), 64'(mk_d(1'b0, 32'hCAFE)));
    tick();
    s_d_valid = 1'b0;
    #1;
    check("t1_no_unexp", 64'(unexpected_resp), 64'd0);

    // Counter is back at zero, so another response to requester 0 is unexpected and sticky
    d_resp("t6_extra", 1'b0);
    #1;
    check("t6_unexp_set", 64'(unexpected_resp), 64'd1);
    tick(); tick();
    check("t6_unexp_sticky", 64'(unexpected_resp), 64'd1);
    do_reset("t6");

    // Both requesters valid every cycle
`ifdef ARB_FIXED_PRIORITY_EN
    alt = 4'b1100;
`else
    alt = 4'b1010;
`endif
    for (int i = 0; i < 4; i++) begin
      m0_a_channel = mk_a(OP_STORE, 14'(100 + i), 32'(i));
      m1_a_channel = mk_a(OP_LOAD, 14'(200 + i), 32'(1000 + i));
      m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
      w = alt[i];
      sb_a.push_back(stamp(w ? m1_a_channel : m0_a_channel, w));
      #1;
      check($sformatf("t2_src_%0d", i), 64'(s_a_channel[SRC]), 64'(w));
      check($sformatf("t2_m1_ready_%0d", i), 64'(m1_a_ready), 64'(w));
      observe_a($sformatf("t2_payload_%0d", i));
      tick();
    end
    // Both at the outstanding limit now
    #1;
    check("t2_both_full", 64'(s_a_valid), 64'd0);
    clear_inputs();
    d_resp("t2_drain0a", 1'b0);
    d_resp("t2_drain0b", 1'b0);
    d_resp("t2_drain1a", 1'b1);
    d_resp("t2_drain1b", 1'b1);
    #1;
    check("t2_drain_no_unexp", 64'(unexpected_resp), 64'd0);
    do_reset("t2");

    // Lock on requester 0 while the slave stalls
    p0 = mk_a(OP_STORE, 14'd33, 32'h55);
    m0_a_channel = p0; m0_a_valid = 1'b1; s_a_ready = 1'b0;
    #1;
    check("t3_offer", 64'(s_a_channel), 64'(stamp(p0, 1'b0)));
    check("t3_m0_ready_stall", 64'(m0_a_ready), 64'd0);
    tick();
    m1_a_channel = mk_a(OP_LOAD, 14'd44, 32'h66); m1_a_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      backpressureslave = (i == 1);
      #1;
      check($sformatf("t3_lock_valid_%0d", i), 64'(s_a_valid), 64'd1);
      check($sformatf("t3_lock_payload_%0d", i), 64'(s_a_channel), 64'(stamp(p0, 1'b0)));
      check($sformatf("t3_m1_blocked_%0d", i), 64'(m1_a_ready), 64'd0);
      tick();
    end
    backpressureslave = 1'b0; s_a_ready = 1'b1;
    sb_a.push_back(stamp(p0, 1'b0));
    #1;
    check("t3_m0_fire", 64'(m0_a_ready), 64'd1);
    check("t3_m1_wait", 64'(m1_a_ready), 64'd0);
    observe_a("t3_payload");
    tick();
`ifdef ARB_FIXED_PRIORITY_EN
    w = 1'b0;
`else
    w = 1'b1;
`endif
    m0_a_channel = mk_a(OP_STORE, 14'd34, 32'h77);
    sb_a.push_back(stamp(w ? m1_a_channel : m0_a_channel, w));
    #1;
    check("t3_next_winner", 64'(s_a_channel[SRC]), 64'(w));
    observe_a("t3_next_payload");
    tick();
    do_reset("t3");

    // Outstanding limit on requester 1
    m1_a_valid = 1'b1; s_a_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m1_a_channel = mk_a(OP_LOAD, 14'(300 + i), 32'(i));
      sb_a.push_back(stamp(m1_a_channel, 1'b1));
      #1;
      check($sformatf("t4_m1_ready_%0d", i), 64'(m1_a_ready), 64'd1);
      observe_a($sformatf("t4_payload_%0d", i));
      tick();
    end
    m1_a_channel = mk_a(OP_LOAD, 14'd302, 32'd2);
    s_d_valid = 1'b1; s_d_channel = mk_d(1'b1, 32'h99); m1_d_ready = 1'b1;
    #1;
    check("t4_blocked_ready", 64'(m1_a_ready), 64'd0);
    check("t4_blocked_valid", 64'(s_a_valid), 64'd0);
    check("t4_resp_accept", 64'(s_d_ready), 64'd1);
    tick();
    s_d_valid = 1'b0;
    sb_a.push_back(stamp(m1_a_channel, 1'b1));
    #1;
    check("t4_readmit", 64'(m1_a_ready), 64'd1);
    observe_a("t4_readmit_payload");
    tick();
    m1_a_valid = 1'b0;

    // Response to requester 1 under its backpressure, with error
    s_d_valid = 1'b1; s_d_channel = mk_d(1'b1, 32'hE0); s_d_error = 1'b1;
    m1_d_ready = 1'b0; m0_d_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t5_s_d_ready_%0d", i), 64'(s_d_ready), 64'd0);
      check($sformatf("t5_m0_d_valid_%0d", i), 64'(m0_d_valid), 64'd0);
      check($sformatf("t5_m1_d_valid_%0d", i), 64'(m1_d_valid), 64'd1);
      check($sformatf("t5_m1_d_error_%0d", i), 64'(m1_d_error), 64'd1);
      tick();
    end
    m1_d_ready = 1'b1;
    #1;
    check("t5_release", 64'(s_d_ready), 64'd1);
    check("t5_m1_payload", 64'(m1_d_channel), 64'(mk_d(1'b1, 32'hE0)));
    tick();
    s_d_valid = 1'b0; s_d_error = 1'b0;
    #1;
    check("t5_no_unexp", 64'(unexpected_resp), 64'd0);

    // Reset in the middle of a locked handshake with a response still in flight
    m0_a_channel = mk_a(OP_STORE, 14'd50, 32'd5); m0_a_valid = 1'b1; s_a_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("t7_rst_s_a_valid", 64'(s_a_valid), 64'd0);
    check("t7_rst_m0_ready", 64'(m0_a_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m0_a_valid = 1'b0; m1_a_valid = 1'b1; m1_a_channel = mk_a(OP_LOAD, 14'd51, 32'd6);
    #1;
    check("t7_lock_cleared", 64'(s_a_valid), 64'd1);
    check("t7_src_after_rst", 64'(s_a_channel[SRC]), 64'd1);
    m1_a_valid = 1'b0;
    tick();
    d_resp("t7_inflight", 1'b1);
    #1;
    check("t7_unexp_after_rst", 64'(unexpected_resp), 64'd1);

    check("sb_a_empty", 64'(sb_a.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
